memory_cycle: RTL

- MEM stage of the 5-stage RISC-V pipeline, directly upstream of the writeback stage.
- Contains the word-organised data memory, with byte/halfword/word loads and stores plus sign/zero extension.
- Owns the MEM/WB pipeline register that produces ResultSrcW, PCPlus4W, ALU_ResultW and ReadDataW for writeback, together with RegWriteW/RdW for the register file and hazard unit.

---
 rtl/memory_cycle.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// MEM stage: word-organised data memory with sub-word access
// and the MEM/WB pipeline register feeding writeback.
module memory_cycle #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EnW,
  input  logic        FlushM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              legal;
  logic              misal;
  logic              bad;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       ldata;
  logic              unused;

  // upper address bits alias the 4 KiB array
  assign unused = ^ALU_ResultM[31:ADDR_W+2];
  assign idx    = ALU_ResultM[ADDR_W+1:2];
  assign lane   = ALU_ResultM[1:0];

  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    unique case (funct3M)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: begin
        legal = 1'b1;
        misal = lane[0];
      end
      3'b010: begin
        legal = 1'b1;
        misal = |lane;
      end
      default: legal = 1'b0;
    endcase
  end

  assign bad = ((MemReadM | MemWriteM) & (misal | ~legal))
             | (MemWriteM & funct3M[2]);

  assign we = MemWriteM & EnW & ~FlushM & ~bad & rst;

  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    unique case (funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[8*lane +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ldata = '0;
    unique case (1'b1)
      (funct3M == 3'b000): ldata = {{24{rbyte[7]}}, rbyte};
      (funct3M == 3'b001): ldata = {{16{rhalf[15]}}, rhalf};
      (funct3M == 3'b010): ldata = rword;
      (funct3M == 3'b100): ldata = {24'd0, rbyte};
      (funct3M == 3'b101): ldata = {16'd0, rhalf};
      default:             ldata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RdW         <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= RESET_PC4;
      MisalignW   <= 1'b0;
    end else if (EnW) begin
      if (FlushM) begin
        RegWriteW   <= 1'b0;
        ResultSrcW  <= 1'b0;
        RdW         <= '0;
        ALU_ResultW <= '0;
        ReadDataW   <= '0;
        PCPlus4W    <= '0;
        MisalignW   <= 1'b0;
      end else begin
        RegWriteW   <= RegWriteM & ~bad;
        ResultSrcW  <= ResultSrcM;
        RdW         <= RdM;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= (MemReadM & ~bad) ? ldata : '0;
        PCPlus4W    <= PCPlus4M;
        MisalignW   <= bad;
      end
    end
  end

endmodule
